// File: rtl/stack_arb_pkg.sv
// Shared types for the arbitrated stack: the arbiter FSM encoding and the helper that
// sizes requester index fields.
package stack_arb_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Width of a requester index; never below 1 bit
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stack_arb_if.sv
// Requester/response bundle between the requesters (master) and stack_arb (slave).
interface stack_arb_if
   import stack_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DWID = 16
) ();

   localparam int IW = idx_w(NREQ);

   logic [NREQ-1:0]      req_push;
   logic [NREQ-1:0]      req_pop;
   logic [NREQ-1:0]      req_lock;
   logic [NREQ*DWID-1:0] req_din;
   logic [NREQ-1:0]      gnt;
   logic                 rsp_v;
   logic [IW-1:0]        rsp_id;
   logic [DWID-1:0]      rsp_data;
   logic                 rsp_err;
   logic                 empty;
   logic                 full;

   modport master (
      output req_push, req_pop, req_lock, req_din,
      input  gnt, rsp_v, rsp_id, rsp_data, rsp_err, empty, full
   );

   modport slave (
      input  req_push, req_pop, req_lock, req_din,
      output gnt, rsp_v, rsp_id, rsp_data, rsp_err, empty, full
   );

endinterface

// File: rtl/stack_arb_stack.sv
// LIFO stack: one push or one pop per cycle, registered pop data with a one-cycle valid.
// dout reads zero whenever dout_v is low.
module stack_arb_stack #(
   parameter int DEPTH = 256,
   parameter int DWID  = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [DWID-1:0] din,
   output logic [DWID-1:0] dout,
   output logic            dout_v
);

   localparam int SW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DWID-1:0] mem [DEPTH];
   logic [SW-1:0]   sp_q, sp_d;
   logic [DWID-1:0] dout_q, dout_d;
   logic            dout_v_q, dout_v_d;
   logic            do_push, do_pop;

   // Self-guarding against overflow/underflow even though the arbiter never asks
   always_comb begin
      do_push  = push && (sp_q != SW'(DEPTH));
      do_pop   = pop && !push && (sp_q != '0);
      sp_d     = sp_q;
      dout_d   = '0;
      dout_v_d = 1'b0;
      if (do_push) begin
         sp_d = sp_q + 1'b1;
      end else if (do_pop) begin
         sp_d     = sp_q - 1'b1;
         dout_d   = mem[AW'(sp_q - 1'b1)];
         dout_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[AW'(sp_q)] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q     <= '0;
         dout_q   <= '0;
         dout_v_q <= 1'b0;
      end else begin
         sp_q     <= sp_d;
         dout_q   <= dout_d;
         dout_v_q <= dout_v_d;
      end
   end

   assign dout   = dout_q;
   assign dout_v = dout_v_q;

endmodule

// File: rtl/stack_arb.sv
// Round-robin arbiter sharing one stack among NREQ requesters, one push or pop per cycle.
// Define STACK_ARB_LOCK_EN to let a granted requester hold exclusive access via req_lock.
module stack_arb
   import stack_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DEPTH = 256,
   parameter int DWID  = 16
) (
   input logic          clk,
   input logic          rst,
   stack_arb_if.slave   bus
);

   localparam int IW = idx_w(NREQ);
   localparam int CW = $clog2(DEPTH + 1);

   arb_state_e      state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   rsp_id_q, rsp_id_d;
   logic [CW-1:0]   count_q, count_d;
   logic            rsp_err_q, rsp_err_d;

   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   win;
   logic            found, win_push, full, empty;
   logic            st_push, st_pop, st_dout_v;
   logic [DWID-1:0] st_din, st_dout;
   int              j;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // Push wins over pop for the same requester; a blocked push also holds back its pop
   always_comb begin
      elig = (bus.req_push & {NREQ{!full}}) | (bus.req_pop & ~bus.req_push);
`ifdef STACK_ARB_LOCK_EN
      if (state_q == LOCKED)
         elig = bus.req_lock[owner_q] ? (elig & (NREQ'(1) << owner_q)) : '0;
`endif
   end

   always_comb begin
      found = 1'b0;
      win   = '0;
      j     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         j = int'(rr_ptr_q) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && elig[IW'(j)]) begin
            found = 1'b1;
            win   = IW'(j);
         end
      end
   end

   assign win_push = bus.req_push[win];
   assign gnt      = found ? (NREQ'(1) << win) : '0;
   assign st_push  = found && win_push;
   assign st_pop   = found && !win_push && !empty;
   assign st_din   = bus.req_din[win*DWID +: DWID];

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_ptr_d  = found ? win : rr_ptr_q;
      count_d   = count_q;
      rsp_id_d  = (found && !win_push) ? win : '0;
      rsp_err_d = found && !win_push && empty;
      if (st_push)     count_d = count_q + 1'b1;
      else if (st_pop) count_d = count_q - 1'b1;
`ifdef STACK_ARB_LOCK_EN
      if (state_q == ARB) begin
         if (found && bus.req_lock[win]) begin
            state_d = LOCKED;
            owner_d = win;
         end
      end else if (!bus.req_lock[owner_q]) begin
         // Owner drops to lowest priority on release
         state_d  = ARB;
         rr_ptr_d = owner_q;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ARB;
         rr_ptr_q  <= IW'(NREQ - 1);
         owner_q   <= '0;
         count_q   <= '0;
         rsp_id_q  <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         count_q   <= count_d;
         rsp_id_q  <= rsp_id_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   stack_arb_stack #(
      .DEPTH (DEPTH),
      .DWID  (DWID)
   ) u_stack (
      .clk    (clk),
      .rst    (rst),
      .push   (st_push),
      .pop    (st_pop),
      .din    (st_din),
      .dout   (st_dout),
      .dout_v (st_dout_v)
   );

   assign bus.gnt      = gnt;
   assign bus.rsp_v    = st_dout_v | rsp_err_q;
   assign bus.rsp_id   = rsp_id_q;
   assign bus.rsp_data = st_dout;
   assign bus.rsp_err  = rsp_err_q;
   assign bus.empty    = empty;
   assign bus.full     = full;

endmodule

// File: tb/tb_stack_arb.sv
// Directed bench for stack_arb (NREQ=4, DEPTH=4, DWID=16); lock expectations follow
// STACK_ARB_LOCK_EN.
module tb_stack_arb;

   logic clk;
   logic rst;
   int   errs;
   int   checks;

   stack_arb_if #(.NREQ(4), .DWID(16)) bus ();

   stack_arb #(.NREQ(4), .DEPTH(4), .DWID(16)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_din(input int i, input logic [15:0] v);
      bus.req_din[i*16 +: 16] = v;
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                          input logic [15:0] d, input logic e);
      chk({tag, "_v"},    32'(bus.rsp_v),    32'(v));
      chk({tag, "_id"},   32'(bus.rsp_id),   32'(id));
      chk({tag, "_data"}, 32'(bus.rsp_data), 32'(d));
      chk({tag, "_err"},  32'(bus.rsp_err),  32'(e));
   endtask

   logic [15:0] drain [4];

   initial begin
      errs = 0;
      checks = 0;
      rst = 1'b1;
      bus.req_push = '0;
      bus.req_pop  = '0;
      bus.req_lock = '0;
      bus.req_din  = '0;
      drain[0] = 16'h11; drain[1] = 16'h0C; drain[2] = 16'h0B; drain[3] = 16'h0A;

      #12;
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk_rsp("rst", 1'b0, 2'd0, 16'h0, 1'b0);
      chk("rst_empty", 32'(bus.empty), 32'h1);
      chk("rst_full", 32'(bus.full), 32'h0);
      tick();
      rst = 1'b0;

      // All four push continuously: grants rotate 0,1,2,3 then stop on full
      set_din(0, 16'h0A); set_din(1, 16'h0B); set_din(2, 16'h0C); set_din(3, 16'h0D);
      bus.req_push = 4'b1111;
      #1 chk("fill_g0", 32'(bus.gnt), 32'b0001);
      tick(); chk("fill_g1", 32'(bus.gnt), 32'b0010);
      tick(); chk("fill_g2", 32'(bus.gnt), 32'b0100);
      tick(); chk("fill_g3", 32'(bus.gnt), 32'b1000);
      tick(); chk("fill_full_gnt", 32'(bus.gnt), 32'h0);
      chk("fill_full", 32'(bus.full), 32'h1);
      chk("fill_empty", 32'(bus.empty), 32'h0);
      bus.req_push = '0;

      // Pop by requester 2 returns top of stack
      bus.req_pop = 4'b0100;
      #1 chk("pop2_gnt", 32'(bus.gnt), 32'b0100);
      tick(); bus.req_pop = '0;
      chk_rsp("pop2", 1'b1, 2'd2, 16'h0D, 1'b0);
      chk("pop2_full", 32'(bus.full), 32'h0);
      tick(); chk("pop2_once", 32'(bus.rsp_v), 32'h0);

      // Refill to full, then a blocked push must yield to a pop
      set_din(1, 16'h0E); bus.req_push = 4'b0010;
      #1 chk("refill_gnt", 32'(bus.gnt), 32'b0010);
      tick(); bus.req_push = '0;
      chk("refill_full", 32'(bus.full), 32'h1);
      set_din(0, 16'h11); bus.req_push = 4'b0001; bus.req_pop = 4'b1000;
      #1 chk("full_popwin", 32'(bus.gnt), 32'b1000);
      tick(); bus.req_pop = '0;
      chk_rsp("full_pop3", 1'b1, 2'd3, 16'h0E, 1'b0);
      chk("full_pushnext", 32'(bus.gnt), 32'b0001);
      tick(); bus.req_push = '0;
      chk("full_again", 32'(bus.full), 32'h1);

      // Drain in LIFO order
      bus.req_pop = 4'b1000;
      for (int k = 0; k < 4; k++) begin
         #1 chk("drain_gnt", 32'(bus.gnt), 32'b1000);
         tick();
         chk_rsp("drain", 1'b1, 2'd3, drain[k], 1'b0);
      end
      bus.req_pop = '0;
      chk("drain_empty", 32'(bus.empty), 32'h1);

      // Pop on empty: granted, error response with zero data
      bus.req_pop = 4'b0010;
      #1 chk("epop_gnt", 32'(bus.gnt), 32'b0010);
      tick(); bus.req_pop = '0;
      chk_rsp("epop", 1'b1, 2'd1, 16'h0, 1'b1);
      chk("epop_empty", 32'(bus.empty), 32'h1);

      // Move rr_ptr to 0 with another empty pop
      bus.req_pop = 4'b0001;
      #1 chk("epop0_gnt", 32'(bus.gnt), 32'b0001);
      tick(); bus.req_pop = '0;
      chk_rsp("epop0", 1'b1, 2'd0, 16'h0, 1'b1);

      // Requester 1 pushes with lock against requester 2
      set_din(1, 16'h21); set_din(2, 16'h22);
      bus.req_push = 4'b0110; bus.req_lock = 4'b0010;
      #1 chk("lk_g0", 32'(bus.gnt), 32'b0010);
      tick();
`ifdef STACK_ARB_LOCK_EN
      chk("lk_g1", 32'(bus.gnt), 32'b0010);
      tick(); chk("lk_g2", 32'(bus.gnt), 32'b0010);
      tick(); bus.req_push = 4'b0100; bus.req_lock = '0;
      #1 chk("lk_release", 32'(bus.gnt), 32'h0);
      tick(); chk("lk_next", 32'(bus.gnt), 32'b0100);
`else
      chk("rr_g1", 32'(bus.gnt), 32'b0100);
      tick(); chk("rr_g2", 32'(bus.gnt), 32'b0010);
      tick(); bus.req_push = 4'b0100; bus.req_lock = '0;
      #1 chk("rr_g3", 32'(bus.gnt), 32'b0100);
`endif
      tick(); bus.req_push = '0;
      chk("lk_full", 32'(bus.full), 32'h1);

      bus.req_pop = 4'b0001;
      #1 chk("lk_pop_gnt", 32'(bus.gnt), 32'b0001);
      tick(); bus.req_pop = '0;
      chk_rsp("lk_pop", 1'b1, 2'd0, 16'h22, 1'b0);

      // Reset while a pop response is in flight
      bus.req_pop = 4'b0001;
      #1 chk("rstpop_gnt", 32'(bus.gnt), 32'b0001);
      #2 rst = 1'b1; bus.req_pop = '0;
      #1 chk("rstmid_gnt", 32'(bus.gnt), 32'h0);
      chk("rstmid_empty", 32'(bus.empty), 32'h1);
      tick();
      chk("rstpop_v", 32'(bus.rsp_v), 32'h0);
      chk("rstpop_empty", 32'(bus.empty), 32'h1);
      chk("rstpop_full", 32'(bus.full), 32'h0);
      rst = 1'b0;
      tick();
      chk("rstpop_nov", 32'(bus.rsp_v), 32'h0);

      // After reset requester 0 has priority again
      set_din(0, 16'h31); set_din(1, 16'h32);
      bus.req_push = 4'b0011;
      #1 chk("post_rst_gnt", 32'(bus.gnt), 32'b0001);
      tick(); bus.req_push = '0;
      chk("post_rst_empty", 32'(bus.empty), 32'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/stack_arb.md
STACK_ARB -- requirements
Module: stack_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter DEPTH, default 256, stack entries.
REQ-003 Parameter DWID, default 16, data width.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_push  input  NREQ  per-requester push request; held until granted.
REQ-007 req_pop  input  NREQ  per-requester pop request; held until granted.
REQ-008 req_lock  input  NREQ  per-requester lock request (atomic sequence).
REQ-009 req_din  input  NREQ*DWID  push data; requester i occupies bits [i*DWID +: DWID].
REQ-010 gnt  output  NREQ  one-hot grant, combinational, same cycle as the accepted operation.
REQ-011 rsp_v  output  1  pop response valid.
REQ-012 rsp_id  output  $clog2(NREQ)  index of the requester that owns the response.
REQ-013 rsp_data  output  DWID  popped data.
REQ-014 rsp_err  output  1  pop was granted on an empty stack; rsp_data is 0.
REQ-015 empty, full  output  1 each  stack occupancy flags, registered-count based.

Function
REQ-016 At most one operation (push or pop) is issued to the stack per cycle; gnt has at most one bit set.
REQ-017 A requester asserting both push and pop is serviced as push only; the pop stays pending.
REQ-018 Eligibility: push eligible only if not full; pop always eligible.
REQ-019 Round-robin: search starts at rr_ptr+1 (mod NREQ); on grant, rr_ptr <= granted index; no grant -> rr_ptr unchanged.
REQ-020 Push grant writes req_din slice of the winner; push+pop are never issued together to the stack.
REQ-021 Pop latency: rsp_v/rsp_id/rsp_data/rsp_err valid exactly 1 cycle after the pop grant, for one cycle.
REQ-022 Pop on empty: granted, stack not accessed, rsp_v=1, rsp_err=1, rsp_data=0 next cycle.
REQ-023 Occupancy count 0..DEPTH kept in arbiter; full = (count==DEPTH), empty = (count==0); no wrap past either bound.
REQ-024 FSM states ARB and LOCKED; ARB -> LOCKED when the granted requester has req_lock=1 in the grant cycle; owner <= that index.
REQ-025 In LOCKED only owner is eligible; others get no grant; LOCKED -> ARB when owner's req_lock deasserts (no grant that cycle required).
REQ-026 Leaving LOCKED sets rr_ptr to owner, so owner has lowest priority next.
REQ-027 Deasserting a request before grant is legal; no operation is issued for it.

Reset
REQ-028 rst asserted: state=ARB, rr_ptr=NREQ-1 (requester 0 first), count=0, rsp_v=0, rsp_err=0, rsp_id=0, rsp_data=0, empty=1, full=0, gnt=0.
REQ-029 rst mid-operation discards any in-flight pop response and any lock; stack contents are considered lost.

Configuration
REQ-030 Macro STACK_ARB_LOCK_EN: defined -> REQ-024..026 active; undefined -> FSM held in ARB, req_lock ignored, pure round-robin.

Structure
REQ-031 Package stack_arb_pkg holds the FSM state encoding (ARB=0, LOCKED=1) and the index-width function for NREQ.
REQ-032 One sub-module: the team's existing stack (DEPTH, DWID), driven with single push or pop only; its dout/dout_v feed rsp_data/rsp_v.

Verification
REQ-033 Reset, then requesters 0..3 all push 0x0A,0x0B,0x0C,0x0D continuously -> grants 0,1,2,3 in successive cycles, count=4.
REQ-034 After REQ-033, requester 2 pops -> next cycle rsp_v=1, rsp_id=2, rsp_data=0x0D, rsp_err=0.
REQ-035 Empty stack, requester 1 pops -> gnt=0010, next cycle rsp_v=1, rsp_err=1, rsp_data=0.
REQ-036 DEPTH=4, fill to full, requester 0 pushes and requester 3 pops -> requester 3 granted, requester 0 granted the following cycle.
REQ-037 With STACK_ARB_LOCK_EN: requester 1 pushes with lock, requester 2 requests -> requester 1 gets 3 consecutive grants; lock drops -> requester 2 granted next.
REQ-038 rst pulsed in the cycle after a pop grant -> rsp_v=0, empty=1, no response delivered.
